// File: rtl/maxpool2d_stream_ctrl.sv
// Frame-at-a-time streaming wrapper around a combinational 2-D max pooler.
// Loads a full input frame, pools it in one cycle, then drains the results.

module maxpool2d #(
    parameter int CH      = 1,
    parameter int IN_H    = 4,
    parameter int IN_W    = 4,
    parameter int K       = 2,
    parameter int STRIDE  = 2,
    parameter int PADDING = 0,
    parameter int WIDTH   = 16,
    localparam int OUT_H  = (IN_H + 2 * PADDING - K) / STRIDE + 1,
    localparam int OUT_W  = (IN_W + 2 * PADDING - K) / STRIDE + 1,
    localparam int N_IN   = CH * IN_H * IN_W,
    localparam int N_OUT  = CH * OUT_H * OUT_W
) (
    input  logic [N_IN*WIDTH-1:0]  in_vec,
    output logic [N_OUT*WIDTH-1:0] out_vec
);
    localparam logic [WIDTH-1:0] PAD = {1'b1, {(WIDTH - 1){1'b0}}};

    always_comb begin
        int r, col, idx;
        logic in_range;
        logic [WIDTH-1:0] best, cand;
        out_vec  = '0;
        r        = 0;
        col      = 0;
        idx      = 0;
        in_range = 1'b0;
        best     = PAD;
        cand     = PAD;
        for (int c = 0; c < CH; c++) begin
            for (int oh = 0; oh < OUT_H; oh++) begin
                for (int ow = 0; ow < OUT_W; ow++) begin
                    best = PAD;
                    for (int kh = 0; kh < K; kh++) begin
                        for (int kw = 0; kw < K; kw++) begin
                            r        = oh * STRIDE + kh - PADDING;
                            col      = ow * STRIDE + kw - PADDING;
                            in_range = (r >= 0) && (r < IN_H) && (col >= 0) && (col < IN_W);
                            // Clamp the index so padded taps never address outside the frame.
                            idx      = in_range ? ((c * IN_H + r) * IN_W + col) : 0;
                            cand     = in_range ? in_vec[idx*WIDTH +: WIDTH] : PAD;
                            if ($signed(cand) > $signed(best)) begin
                                best = cand;
                            end
                        end
                    end
                    out_vec[((c * OUT_H + oh) * OUT_W + ow)*WIDTH +: WIDTH] = best;
                end
            end
        end
    end
endmodule

module maxpool2d_stream_ctrl #(
    parameter int CH      = 1,
    parameter int IN_H    = 4,
    parameter int IN_W    = 4,
    parameter int K       = 2,
    parameter int STRIDE  = 2,
    parameter int PADDING = 0,
    parameter int WIDTH   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             frame_err
);
    localparam int OUT_H = (IN_H + 2 * PADDING - K) / STRIDE + 1;
    localparam int OUT_W = (IN_W + 2 * PADDING - K) / STRIDE + 1;
    localparam int N_IN  = CH * IN_H * IN_W;
    localparam int N_OUT = CH * OUT_H * OUT_W;
    localparam int LW    = $clog2(N_IN + 1);
    localparam int DW    = $clog2(N_OUT + 1);
    localparam logic [LW-1:0] LAST_IN  = LW'(N_IN - 1);
    localparam logic [DW-1:0] LAST_OUT = DW'(N_OUT - 1);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          load_cnt_q, load_cnt_d;
    logic [DW-1:0]          drain_cnt_q, drain_cnt_d;
    logic [N_IN*WIDTH-1:0]  frame_q, frame_d;
    logic [N_OUT*WIDTH-1:0] outbuf_q, outbuf_d;
    logic                   err_q, err_d;
    logic [N_OUT*WIDTH-1:0] pool_vec;

    maxpool2d #(
        .CH(CH), .IN_H(IN_H), .IN_W(IN_W), .K(K),
        .STRIDE(STRIDE), .PADDING(PADDING), .WIDTH(WIDTH)
    ) u_pool (
        .in_vec (frame_q),
        .out_vec(pool_vec)
    );

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        drain_cnt_d = drain_cnt_q;
        frame_d     = frame_q;
        outbuf_d    = outbuf_q;
        err_d       = err_q;
        in_ready    = (state_q == S_LOAD) && !rst;
        out_valid   = (state_q == S_DRAIN);
        out_data    = '0;
        out_last    = 1'b0;
        busy        = (state_q == S_COMPUTE) || (state_q == S_DRAIN);
        frame_err   = err_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    frame_d[int'(load_cnt_q)*WIDTH +: WIDTH] = in_data;
                    // Framing is count-based; a stray in_last only flags an error.
                    if (in_last != (load_cnt_q == LAST_IN)) begin
                        err_d = 1'b1;
                    end
                    if (load_cnt_q == LAST_IN) begin
                        load_cnt_d = '0;
                        state_d    = S_COMPUTE;
                    end else begin
                        load_cnt_d = load_cnt_q + LW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                outbuf_d = pool_vec;
                state_d  = S_DRAIN;
            end
            S_DRAIN: begin
                out_data = outbuf_q[int'(drain_cnt_q)*WIDTH +: WIDTH];
                out_last = (drain_cnt_q == LAST_OUT);
                if (out_ready) begin
                    if (drain_cnt_q == LAST_OUT) begin
                        drain_cnt_d = '0;
                        state_d     = S_LOAD;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DW'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            load_cnt_q  <= '0;
            drain_cnt_q <= '0;
            frame_q     <= '0;
            outbuf_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            frame_q     <= frame_d;
            outbuf_q    <= outbuf_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_maxpool2d_stream_ctrl.sv
// Directed bench for maxpool2d_stream_ctrl: four configurations share one
// stimulus bus, selected by sel so only one instance is active at a time.

module tb_maxpool2d_stream_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    int          sel = 0;

    logic        iv_v [4];
    logic        rdy_v[4];
    logic        ov_v [4];
    logic [15:0] od_v [4];
    logic        ol_v [4];
    logic        bz_v [4];
    logic        fe_v [4];

    logic        rdy, ov, ol, bz, fe;
    logic [15:0] od;

    int tests = 0;
    int fails = 0;
    int stuck = 0;
    logic [15:0] frame_m [32];

    always #5 clk = ~clk;

    assign iv_v[0] = in_valid && (sel == 0);
    assign iv_v[1] = in_valid && (sel == 1);
    assign iv_v[2] = in_valid && (sel == 2);
    assign iv_v[3] = in_valid && (sel == 3);
    assign rdy = rdy_v[sel];
    assign ov  = ov_v[sel];
    assign od  = od_v[sel];
    assign ol  = ol_v[sel];
    assign bz  = bz_v[sel];
    assign fe  = fe_v[sel];

    maxpool2d_stream_ctrl u_a (
        .clk(clk), .rst(rst), .in_valid(iv_v[0]), .in_ready(rdy_v[0]), .in_data(in_data),
        .in_last(in_last), .out_valid(ov_v[0]), .out_ready(out_ready), .out_data(od_v[0]),
        .out_last(ol_v[0]), .busy(bz_v[0]), .frame_err(fe_v[0]));

    maxpool2d_stream_ctrl #(.IN_H(2), .IN_W(2)) u_s (
        .clk(clk), .rst(rst), .in_valid(iv_v[1]), .in_ready(rdy_v[1]), .in_data(in_data),
        .in_last(in_last), .out_valid(ov_v[1]), .out_ready(out_ready), .out_data(od_v[1]),
        .out_last(ol_v[1]), .busy(bz_v[1]), .frame_err(fe_v[1]));

    maxpool2d_stream_ctrl #(.IN_H(2), .IN_W(2), .PADDING(1)) u_p (
        .clk(clk), .rst(rst), .in_valid(iv_v[2]), .in_ready(rdy_v[2]), .in_data(in_data),
        .in_last(in_last), .out_valid(ov_v[2]), .out_ready(out_ready), .out_data(od_v[2]),
        .out_last(ol_v[2]), .busy(bz_v[2]), .frame_err(fe_v[2]));

    maxpool2d_stream_ctrl #(.CH(2)) u_m (
        .clk(clk), .rst(rst), .in_valid(iv_v[3]), .in_ready(rdy_v[3]), .in_data(in_data),
        .in_last(in_last), .out_valid(ov_v[3]), .out_ready(out_ready), .out_data(od_v[3]),
        .out_last(ol_v[3]), .busy(bz_v[3]), .frame_err(fe_v[3]));

    // Inputs change 1 time unit after each rising edge; outputs are read there too.
    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
    endtask

    task automatic send_elem(input logic [15:0] d, input logic lst, input int gap);
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = lst;
        n = 0;
        while (!rdy && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) stuck++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv_elem(input int stall_pct, output logic [15:0] d, output logic l,
                             output logic stable);
        int n;
        logic v, r, got;
        n = 0;
        got = 1'b0;
        stable = 1'b1;
        d = '0;
        l = 1'b0;
        while (!got && n < 200) begin
            r = ($urandom_range(0, 99) >= stall_pct);
            out_ready = r;
            v = ov;
            d = od;
            l = ol;
            @(posedge clk); #1;
            n++;
            if (v && r) got = 1'b1;
            else if (v && (ov !== 1'b1 || od !== d || ol !== l)) stable = 1'b0;
        end
        out_ready = 1'b0;
        if (!got) stuck++;
    endtask

    function automatic logic [15:0] ref_pool(input int c, input int oh, input int ow);
        logic [15:0] best;
        logic [15:0] v;
        best = 16'h8000;
        for (int dh = 0; dh < 2; dh++) begin
            for (int dw = 0; dw < 2; dw++) begin
                v = frame_m[c * 16 + (2 * oh + dh) * 4 + 2 * ow + dw];
                if ($signed(v) > $signed(best)) best = v;
            end
        end
        return best;
    endfunction

    task automatic test_reset();
        sel = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (rdy !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 0", rdy); end
        tests++;
        if (ov !== 1'b0 || od !== 16'h0 || ol !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_out: got v=%b d=%h l=%b expected 0/0000/0", ov, od, ol);
        end
        tests++;
        if (bz !== 1'b0 || fe !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_flags: got busy=%b err=%b expected 0/0", bz, fe);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (rdy !== 1'b1) begin fails++; $display("[TB] FAIL reset_release_ready: got %b expected 1", rdy); end
    endtask

    task automatic test_basic();
        logic [15:0] exp_d [4] = '{16'd5, 16'd7, 16'd13, 16'd15};
        logic [15:0] d;
        logic l, st;
        sel = 0;
        stuck = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_elem(16'(i), i == 15, 0);
        tests++;
        if (ov !== 1'b0 || bz !== 1'b1 || rdy !== 1'b0) begin
            fails++; $display("[TB] FAIL basic_compute: got v=%b busy=%b rdy=%b expected 0/1/0", ov, bz, rdy);
        end
        @(posedge clk); #1;
        tests++;
        if (ov !== 1'b1) begin fails++; $display("[TB] FAIL basic_latency: got out_valid=%b expected 1", ov); end
        tests++;
        if (rdy !== 1'b0) begin fails++; $display("[TB] FAIL basic_drain_ready: got %b expected 0", rdy); end
        for (int i = 0; i < 4; i++) begin
            recv_elem(0, d, l, st);
            tests++;
            if (d !== exp_d[i] || l !== (i == 3)) begin
                fails++; $display("[TB] FAIL basic_out%0d: got %h/%b expected %h/%b", i, d, l, exp_d[i], i == 3);
            end
        end
        tests++;
        if (ov !== 1'b0 || rdy !== 1'b1 || bz !== 1'b0) begin
            fails++; $display("[TB] FAIL basic_return: got v=%b rdy=%b busy=%b expected 0/1/0", ov, rdy, bz);
        end
        tests++;
        if (stuck !== 0) begin fails++; $display("[TB] FAIL basic_timeout: got %0d expected 0", stuck); end
    endtask

    task automatic test_signed();
        logic [15:0] vals [4] = '{16'hFF00, 16'hFFFF, 16'h8001, 16'hFE00};
        logic [15:0] d;
        logic l, st;
        sel = 1;
        stuck = 0;
        for (int i = 0; i < 4; i++) send_elem(vals[i], i == 3, 0);
        recv_elem(0, d, l, st);
        tests++;
        if (d !== 16'hFFFF || l !== 1'b1) begin
            fails++; $display("[TB] FAIL signed_out: got %h/%b expected ffff/1", d, l);
        end
        tests++;
        if (ov !== 1'b0 || rdy !== 1'b1 || stuck !== 0) begin
            fails++; $display("[TB] FAIL signed_return: got v=%b rdy=%b stuck=%0d expected 0/1/0", ov, rdy, stuck);
        end
    endtask

    task automatic test_padding();
        logic [15:0] vals [4] = '{16'hFFFD, 16'hFFFB, 16'h0007, 16'h0002};
        logic [15:0] d;
        logic l, st;
        sel = 2;
        stuck = 0;
        for (int i = 0; i < 4; i++) send_elem(vals[i], i == 3, 0);
        for (int i = 0; i < 4; i++) begin
            recv_elem(0, d, l, st);
            tests++;
            if (d !== vals[i] || l !== (i == 3)) begin
                fails++; $display("[TB] FAIL pad_out%0d: got %h/%b expected %h/%b", i, d, l, vals[i], i == 3);
            end
        end
        tests++;
        if (stuck !== 0) begin fails++; $display("[TB] FAIL pad_timeout: got %0d expected 0", stuck); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d, e;
        logic l, st;
        sel = 3;
        stuck = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 32; i++) frame_m[i] = 16'($urandom);
            for (int i = 0; i < 32; i++) send_elem(frame_m[i], i == 31, int'($urandom_range(0, 1)));
            for (int i = 0; i < 8; i++) begin
                e = ref_pool(i / 4, (i % 4) / 2, i % 2);
                recv_elem(50, d, l, st);
                tests++;
                if (d !== e || l !== (i == 7) || st !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL b2b_f%0d_out%0d: got %h/%b stable=%b expected %h/%b stable=1",
                             f, i, d, l, st, e, i == 7);
                end
            end
        end
        tests++;
        if (ov !== 1'b0 || fe !== 1'b0 || stuck !== 0) begin
            fails++; $display("[TB] FAIL b2b_end: got v=%b err=%b stuck=%0d expected 0/0/0", ov, fe, stuck);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [15:0] exp_d [4] = '{16'd5, 16'd7, 16'd13, 16'd15};
        logic [15:0] d;
        logic l, st;
        sel = 0;
        stuck = 0;
        for (int i = 0; i < 16; i++) send_elem(16'(i + 100), i == 15, 0);
        for (int i = 0; i < 2; i++) recv_elem(0, d, l, st);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        tests++;
        if (ov !== 1'b0 || rdy !== 1'b1 || bz !== 1'b0 || od !== 16'h0) begin
            fails++; $display("[TB] FAIL rst_drain: got v=%b rdy=%b busy=%b d=%h expected 0/1/0/0000", ov, rdy, bz, od);
        end
        for (int i = 0; i < 16; i++) send_elem(16'(i), i == 15, 0);
        for (int i = 0; i < 4; i++) begin
            recv_elem(0, d, l, st);
            tests++;
            if (d !== exp_d[i] || l !== (i == 3)) begin
                fails++; $display("[TB] FAIL rst_fresh_out%0d: got %h/%b expected %h/%b", i, d, l, exp_d[i], i == 3);
            end
        end
        tests++;
        if (stuck !== 0) begin fails++; $display("[TB] FAIL rst_timeout: got %0d expected 0", stuck); end
    endtask

    task automatic test_frame_err();
        logic [15:0] exp_d [4] = '{16'd5, 16'd7, 16'd13, 16'd15};
        logic [15:0] d;
        logic l, st;
        sel = 0;
        stuck = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_elem(16'(i), i == 9, 0);
            if (i == 8) begin
                tests++;
                if (fe !== 1'b0) begin fails++; $display("[TB] FAIL ferr_before: got %b expected 0", fe); end
            end
            if (i == 9) begin
                tests++;
                if (fe !== 1'b1 || rdy !== 1'b1) begin
                    fails++; $display("[TB] FAIL ferr_set: got err=%b rdy=%b expected 1/1", fe, rdy);
                end
            end
        end
        tests++;
        if (bz !== 1'b1) begin fails++; $display("[TB] FAIL ferr_complete: got busy=%b expected 1", bz); end
        for (int i = 0; i < 4; i++) begin
            recv_elem(0, d, l, st);
            tests++;
            if (d !== exp_d[i] || l !== (i == 3)) begin
                fails++; $display("[TB] FAIL ferr_out%0d: got %h/%b expected %h/%b", i, d, l, exp_d[i], i == 3);
            end
        end
        tests++;
        if (fe !== 1'b1) begin fails++; $display("[TB] FAIL ferr_sticky: got %b expected 1", fe); end
        do_reset();
        tests++;
        if (fe !== 1'b0 || stuck !== 0) begin
            fails++; $display("[TB] FAIL ferr_clear: got err=%b stuck=%0d expected 0/0", fe, stuck);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_padding();
        test_back_to_back();
        test_reset_mid_drain();
        test_frame_err();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
